vc_arbiter: RTL and testbench



---
 rtl/vc_arbiter.sv | 114 +++++++++++
 tb/tb_vc_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_arbiter.sv
// Grants queued VC selections into pops from four VC FIFOs and pushes into one output FIFO.
// Heads whose VC stays empty for TIMEOUT cycles are discarded; lost and discarded requests are counted.
module vc_arbiter #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       req_valid,
  input  logic [1:0] req_vc,
  input  logic [3:0] vc_empty,
  input  logic       out_full,
  output logic       req_ready,
  output logic [3:0] pop,
  output logic       push,
  output logic [1:0] grant_vc,
  output logic       idle,
  output logic [7:0] drop_cnt,
  output logic [7:0] skip_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ARB, WAIT} state_t;

  state_t                state, state_n;
  logic [DEPTH-1:0][1:0] q_mem;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_n;
  logic [3:0]            wait_cnt, wait_n;
  logic                  last_vld;
  logic                  enq, deq, grant, skip;
  logic [1:0]            head;
  logic                  head_ok;

  assign req_ready = (count < CW'(DEPTH));
  assign enq       = enb & req_valid & req_ready;
  assign head      = q_mem[rd_ptr];
  // The VC FIFO empty flag lags a pop by a cycle, so the VC just granted is treated as empty.
  assign head_ok   = !vc_empty[head] && !(last_vld && (grant_vc == head));

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    grant   = 1'b0;
    skip    = 1'b0;
    if (enb) begin
      case (state)
        IDLE: if (enq) state_n = ARB;
        ARB: if (!out_full) begin
          if (head_ok) grant = 1'b1;
          else if (TIMEOUT == 1) skip = 1'b1;
          else begin
            state_n = WAIT;
            wait_n  = 4'd1;
          end
        end
        WAIT: if (!out_full) begin
          if (head_ok) begin
            grant  = 1'b1;
            wait_n = 4'd0;
          end else if (wait_cnt + 4'd1 >= 4'(TIMEOUT)) begin
            skip   = 1'b1;
            wait_n = 4'd0;
          end else begin
            wait_n = wait_cnt + 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    deq     = grant | skip;
    count_n = count + CW'(enq) - CW'(deq);
    if (deq) state_n = (count_n != '0) ? ARB : IDLE;
  end

  always_ff @(posedge clk) begin
    if (enq) q_mem[wr_ptr] <= req_vc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
      last_vld <= 1'b0;
      pop      <= '0;
      push     <= 1'b0;
      grant_vc <= '0;
      idle     <= 1'b1;
      drop_cnt <= '0;
      skip_cnt <= '0;
    end else if (!enb) begin
      pop  <= '0;
      push <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      wait_cnt <= wait_n;
      idle     <= (state_n == IDLE);
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      pop      <= {4{grant}} & (4'b0001 << head);
      push     <= grant;
      last_vld <= grant;
      if (grant) grant_vc <= head;
      if (req_valid && !req_ready && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      if (skip && (skip_cnt != 8'hFF)) skip_cnt <= skip_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_vc_arbiter.sv
// Scenario bench for vc_arbiter: expected grants are queued at stimulus time and popped on each push.
module tb_vc_arbiter;
  logic       clk = 1'b0;
  logic       rst, enb, req_valid, out_full;
  logic [1:0] req_vc;
  logic [3:0] vc_empty;
  logic       req_ready, push, idle;
  logic [3:0] pop;
  logic [1:0] grant_vc;
  logic [7:0] drop_cnt, skip_cnt;

  int vecs = 0;
  int errs = 0;
  logic [1:0] sb[$];

  vc_arbiter #(.DEPTH(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .enb(enb), .req_valid(req_valid), .req_vc(req_vc),
    .vc_empty(vc_empty), .out_full(out_full), .req_ready(req_ready), .pop(pop),
    .push(push), .grant_vc(grant_vc), .idle(idle), .drop_cnt(drop_cnt), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enb = 1'b1; req_valid = 1'b0; req_vc = 2'd0; vc_empty = 4'h0; out_full = 1'b0;
    tick(); tick();
    rst = 1'b0;
    vecs++;
    if ({pop, push, grant_vc, idle} !== 8'b0000_0_00_1) begin
      errs++; $display("FAIL reset_outputs: got pop=%b push=%b gvc=%0d idle=%b want 0000/0/0/1", pop, push, grant_vc, idle);
    end
    vecs++;
    if ({drop_cnt, skip_cnt, req_ready} !== 17'h0_0001) begin
      errs++; $display("FAIL reset_counts: got drop=%0d skip=%0d ready=%b want 0/0/1", drop_cnt, skip_cnt, req_ready);
    end
    tick();
  endtask

  task automatic test_order();
    logic [1:0] v [4];
    logic [1:0] e;
    logic [3:0] oh;
    v = '{2'd2, 2'd0, 2'd1, 2'd3};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        req_valid = 1'b1; req_vc = v[i]; sb.push_back(v[i]);
      end else req_valid = 1'b0;
      tick();
      vecs++;
      if (i == 0) begin
        if ({pop, push, idle} !== 6'b0) begin
          errs++; $display("FAIL order_latency: got pop=%b push=%b idle=%b want 0000/0/0", pop, push, idle);
        end
      end else if (sb.size() == 0) begin
        errs++; $display("FAIL order_sb: scoreboard empty, want entry");
      end else begin
        e = sb.pop_front(); oh = 4'b0001 << e;
        if ({pop, push, grant_vc} !== {oh, 1'b1, e}) begin
          errs++; $display("FAIL order_grant%0d: got pop=%b push=%b gvc=%0d want %b/1/%0d", i, pop, push, grant_vc, oh, e);
        end
      end
    end
    vecs++;
    if (idle !== 1'b1) begin errs++; $display("FAIL order_idle: got %b want 1", idle); end
    tick();
    vecs++;
    if ({pop, push} !== 5'b0) begin errs++; $display("FAIL order_end: got pop=%b push=%b want 0", pop, push); end
  endtask

  task automatic test_bubble();
    logic [1:0] e;
    req_valid = 1'b1; req_vc = 2'd1; sb.push_back(2'd1);
    tick();
    req_vc = 2'd1; sb.push_back(2'd1);
    tick();
    e = sb.pop_front();
    vecs++;
    if ({pop, push} !== {4'b0001 << e, 1'b1}) begin errs++; $display("FAIL bubble_first: got pop=%b push=%b want 0010/1", pop, push); end
    req_valid = 1'b0;
    tick();
    vecs++;
    if ({pop, push} !== 5'b0) begin errs++; $display("FAIL bubble_gap: got pop=%b push=%b want 0000/0", pop, push); end
    tick();
    e = sb.pop_front();
    vecs++;
    if ({pop, push} !== {4'b0001 << e, 1'b1}) begin errs++; $display("FAIL bubble_second: got pop=%b push=%b want 0010/1", pop, push); end
    tick();
    vecs++;
    if ({pop, idle} !== 5'b0000_1) begin errs++; $display("FAIL bubble_end: got pop=%b idle=%b want 0000/1", pop, idle); end
  endtask

  task automatic test_full();
    logic [1:0] e;
    out_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_vc = 2'(i); sb.push_back(2'(i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (req_ready !== 1'b0) begin errs++; $display("FAIL full_ready%0d: got %b want 0", i, req_ready); end
      req_valid = 1'b1; req_vc = 2'd0;
      tick();
      vecs++;
      if (pop !== 4'b0) begin errs++; $display("FAIL full_nopop%0d: got %b want 0000", i, pop); end
    end
    req_valid = 1'b0;
    vecs++;
    if (drop_cnt !== 8'd3) begin errs++; $display("FAIL full_drops: got %0d want 3", drop_cnt); end
    out_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = sb.pop_front();
      vecs++;
      if ({pop, push} !== {4'b0001 << e, 1'b1}) begin
        errs++; $display("FAIL full_grant%0d: got pop=%b push=%b want %b/1", i, pop, push, 4'b0001 << e);
      end
    end
    vecs++;
    if (idle !== 1'b1) begin errs++; $display("FAIL full_idle: got %b want 1", idle); end
    tick();
  endtask

  task automatic test_skip();
    logic [1:0] e;
    vc_empty = 4'b1000;
    req_valid = 1'b1; req_vc = 2'd3;
    tick();
    req_vc = 2'd0; sb.push_back(2'd0);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    vecs++;
    if ({pop, skip_cnt} !== 12'h0_00) begin errs++; $display("FAIL skip_early: got pop=%b skip=%0d want 0000/0", pop, skip_cnt); end
    tick();
    vecs++;
    if ({pop, skip_cnt} !== 12'h0_01) begin errs++; $display("FAIL skip_count: got pop=%b skip=%0d want 0000/1", pop, skip_cnt); end
    tick();
    e = sb.pop_front();
    vecs++;
    if ({pop, push} !== {4'b0001 << e, 1'b1}) begin errs++; $display("FAIL skip_next: got pop=%b push=%b want 0001/1", pop, push); end
    vc_empty = 4'h0;
    tick();
  endtask

  task automatic test_enb();
    logic [1:0] e;
    req_valid = 1'b1; req_vc = 2'd2; sb.push_back(2'd2);
    tick();
    req_valid = 1'b0;
    tick();
    e = sb.pop_front();
    vecs++;
    if ({pop, push} !== {4'b0001 << e, 1'b1}) begin errs++; $display("FAIL enb_grant: got pop=%b push=%b want 0100/1", pop, push); end
    enb = 1'b0;
    tick();
    vecs++;
    if ({pop, push} !== 5'b0) begin errs++; $display("FAIL enb_clear: got pop=%b push=%b want 0000/0", pop, push); end
    enb = 1'b1;
    tick();
    vc_empty = 4'b1000;
    req_valid = 1'b1; req_vc = 2'd3;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    enb = 1'b0; req_valid = 1'b1; req_vc = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++;
      if ({pop, push, idle, skip_cnt} !== {4'b0, 1'b0, 1'b0, 8'd1}) begin
        errs++; $display("FAIL enb_freeze%0d: got pop=%b push=%b idle=%b skip=%0d want 0000/0/0/1", i, pop, push, idle, skip_cnt);
      end
    end
    enb = 1'b1; req_valid = 1'b0;
    tick();
    vecs++;
    if (skip_cnt !== 8'd1) begin errs++; $display("FAIL enb_resume: got skip=%0d want 1", skip_cnt); end
    tick();
    vecs++;
    if ({skip_cnt, idle, drop_cnt} !== {8'd2, 1'b1, 8'd3}) begin
      errs++; $display("FAIL enb_timeout: got skip=%0d idle=%b drop=%0d want 2/1/3", skip_cnt, idle, drop_cnt);
    end
    vc_empty = 4'h0;
    tick();
  endtask

  task automatic test_rst_mid();
    logic [1:0] e;
    req_valid = 1'b1; req_vc = 2'd0; sb.push_back(2'd0);
    tick();
    req_vc = 2'd1; sb.push_back(2'd1);
    tick();
    e = sb.pop_front();
    vecs++;
    if ({pop, push} !== {4'b0001 << e, 1'b1}) begin errs++; $display("FAIL rst_pre_grant: got pop=%b push=%b want 0001/1", pop, push); end
    req_vc = 2'd2; rst = 1'b1;
    tick();
    sb.delete();
    vecs++;
    if ({pop, push, idle, req_ready, grant_vc} !== {4'b0, 1'b0, 1'b1, 1'b1, 2'd0}) begin
      errs++; $display("FAIL rst_mid_out: got pop=%b push=%b idle=%b ready=%b gvc=%0d want 0000/0/1/1/0", pop, push, idle, req_ready, grant_vc);
    end
    vecs++;
    if ({drop_cnt, skip_cnt} !== 16'h0) begin errs++; $display("FAIL rst_mid_cnt: got drop=%0d skip=%0d want 0/0", drop_cnt, skip_cnt); end
    rst = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if ({pop, idle} !== 5'b0000_1) begin errs++; $display("FAIL rst_discard%0d: got pop=%b idle=%b want 0000/1", i, pop, idle); end
    end
  endtask

  task automatic test_sat();
    out_full = 1'b1; req_valid = 1'b1; req_vc = 2'd1;
    for (int i = 0; i < 4 + 254; i++) tick();
    vecs++;
    if (drop_cnt !== 8'd254) begin errs++; $display("FAIL sat_254: got %0d want 254", drop_cnt); end
    for (int i = 0; i < 46; i++) tick();
    vecs++;
    if ({drop_cnt, pop} !== {8'd255, 4'b0}) begin errs++; $display("FAIL sat_255: got drop=%0d pop=%b want 255/0000", drop_cnt, pop); end
    req_valid = 1'b0; out_full = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_order();
    test_bubble();
    test_full();
    test_skip();
    test_enb();
    test_rst_mid();
    test_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
